// File: rtl/multicycle_ctrl.sv
// Main sequencing FSM for the multicycle RV32I core: drives the shared ALU, the unified memory
// port, IR/PC enables and register-file writes. It also contains the main, ALU and ImmSrc decoders.
module multicycle_ctrl #(
  parameter int unsigned OP_WIDTH       = 7,
  parameter int unsigned FUNCT3_WIDTH   = 3,
  parameter int unsigned ALU_CTRL_WIDTH = 3,
  parameter int unsigned IMM_SRC_WIDTH  = 2,
  parameter int unsigned STATE_WIDTH    = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [OP_WIDTH-1:0]       op,
  input  logic [FUNCT3_WIDTH-1:0]   funct3,
  input  logic                      funct7_5,
  input  logic                      Zero,
  input  logic                      MemReady,
  output logic                      MemRead,
  output logic                      MemWrite,
  output logic                      AdrSrc,
  output logic                      IRWrite,
  output logic                      PCWrite,
  output logic                      RegWrite,
  output logic [1:0]                ResultSrc,
  output logic [1:0]                ALUSrcA,
  output logic [1:0]                ALUSrcB,
  output logic [ALU_CTRL_WIDTH-1:0] ALUControl,
  output logic [IMM_SRC_WIDTH-1:0]  ImmSrc,
  output logic                      Illegal,
  output logic [STATE_WIDTH-1:0]    State
);

  typedef enum logic [STATE_WIDTH-1:0] {
    StFetch    = STATE_WIDTH'(0),
    StDecode   = STATE_WIDTH'(1),
    StMemAdr   = STATE_WIDTH'(2),
    StMemRead  = STATE_WIDTH'(3),
    StMemWb    = STATE_WIDTH'(4),
    StMemWrite = STATE_WIDTH'(5),
    StExecR    = STATE_WIDTH'(6),
    StAluWb    = STATE_WIDTH'(7),
    StExecI    = STATE_WIDTH'(8),
    StJal      = STATE_WIDTH'(9),
    StBeq      = STATE_WIDTH'(10),
    StIllegal  = STATE_WIDTH'(11)
  } state_e;

  localparam logic [OP_WIDTH-1:0] OpLoad   = OP_WIDTH'(7'b0000011);
  localparam logic [OP_WIDTH-1:0] OpStore  = OP_WIDTH'(7'b0100011);
  localparam logic [OP_WIDTH-1:0] OpRType  = OP_WIDTH'(7'b0110011);
  localparam logic [OP_WIDTH-1:0] OpIType  = OP_WIDTH'(7'b0010011);
  localparam logic [OP_WIDTH-1:0] OpJal    = OP_WIDTH'(7'b1101111);
  localparam logic [OP_WIDTH-1:0] OpBranch = OP_WIDTH'(7'b1100011);

  state_e                    r_state, w_next;
  logic                      w_mem_read, w_mem_write, w_adr_src, w_ir_write, w_pc_write;
  logic                      w_reg_write, w_illegal;
  logic [1:0]                w_result_src, w_alu_src_a, w_alu_src_b, w_alu_op;
  logic [ALU_CTRL_WIDTH-1:0] w_alu_ctrl;
  logic [IMM_SRC_WIDTH-1:0]  w_imm_src;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= StFetch;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_adr_src    = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_illegal    = 1'b0;
    w_result_src = 2'b00;
    w_alu_src_a  = 2'b00;
    w_alu_src_b  = 2'b00;
    w_alu_op     = 2'b00;
    case (r_state)
      StFetch: begin
        w_mem_read   = 1'b1;
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
        w_ir_write   = MemReady;
        w_pc_write   = MemReady;
        if (MemReady) w_next = StDecode;
      end
      StDecode: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b01;
        case (op)
          OpLoad, OpStore: w_next = StMemAdr;
          OpRType:         w_next = StExecR;
          OpIType:         w_next = StExecI;
          OpJal:           w_next = StJal;
          OpBranch:        w_next = StBeq;
          default:         w_next = StIllegal;
        endcase
      end
      StMemAdr: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_next      = op[5] ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        w_mem_read = 1'b1;
        w_adr_src  = 1'b1;
        if (MemReady) w_next = StMemWb;
      end
      StMemWb: begin
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
        w_next       = StFetch;
      end
      StMemWrite: begin
        w_mem_write = 1'b1;
        w_adr_src   = 1'b1;
        if (MemReady) w_next = StFetch;
      end
      StExecR: begin
        w_alu_src_a = 2'b10;
        w_alu_op    = 2'b10;
        w_next      = StAluWb;
      end
      StExecI: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_alu_op    = 2'b10;
        w_next      = StAluWb;
      end
      StAluWb: begin
        w_reg_write = 1'b1;
        w_next      = StFetch;
      end
      StJal: begin
        // ALUOut still holds the target from DECODE; ALU now forms PC+4 for the link
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b10;
        w_pc_write  = 1'b1;
        w_next      = StAluWb;
      end
      StBeq: begin
        w_alu_src_a = 2'b10;
        w_alu_op    = 2'b01;
        w_pc_write  = Zero;
        w_next      = StFetch;
      end
      StIllegal: w_illegal = 1'b1;
      default:   w_next = StFetch;
    endcase
  end

  always_comb begin
    w_alu_ctrl = ALU_CTRL_WIDTH'(3'b000);
    case (w_alu_op)
      2'b01: w_alu_ctrl = ALU_CTRL_WIDTH'(3'b001);
      2'b10: begin
        case (funct3)
          FUNCT3_WIDTH'(3'b000): w_alu_ctrl = (op[5] & funct7_5) ? ALU_CTRL_WIDTH'(3'b001)
                                                                 : ALU_CTRL_WIDTH'(3'b000);
          FUNCT3_WIDTH'(3'b010): w_alu_ctrl = ALU_CTRL_WIDTH'(3'b101);
          FUNCT3_WIDTH'(3'b110): w_alu_ctrl = ALU_CTRL_WIDTH'(3'b011);
          FUNCT3_WIDTH'(3'b111): w_alu_ctrl = ALU_CTRL_WIDTH'(3'b010);
          default:               w_alu_ctrl = ALU_CTRL_WIDTH'(3'b000);
        endcase
      end
      default: w_alu_ctrl = ALU_CTRL_WIDTH'(3'b000);
    endcase
  end

  always_comb begin
    case (op)
      OpStore:  w_imm_src = IMM_SRC_WIDTH'(2'b01);
      OpBranch: w_imm_src = IMM_SRC_WIDTH'(2'b10);
      OpJal:    w_imm_src = IMM_SRC_WIDTH'(2'b11);
      default:  w_imm_src = IMM_SRC_WIDTH'(2'b00);
    endcase
  end

  // Everything is held at zero while reset is asserted so no write can retire mid-reset
  assign MemRead    = RST & w_mem_read;
  assign MemWrite   = RST & w_mem_write;
  assign AdrSrc     = RST & w_adr_src;
  assign IRWrite    = RST & w_ir_write;
  assign PCWrite    = RST & w_pc_write;
  assign RegWrite   = RST & w_reg_write;
  assign Illegal    = RST & w_illegal;
  assign ResultSrc  = RST ? w_result_src : 2'b00;
  assign ALUSrcA    = RST ? w_alu_src_a : 2'b00;
  assign ALUSrcB    = RST ? w_alu_src_b : 2'b00;
  assign ALUControl = RST ? w_alu_ctrl : '0;
  assign ImmSrc     = RST ? w_imm_src : '0;
  assign State      = RST ? r_state : '0;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: instruction-level traces compared each cycle against a
// per-state output table derived from the instruction classes.
module tb_multicycle_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7_5, Zero, MemReady;
  logic        MemRead, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, Illegal;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0]  ALUControl;
  logic [3:0]  State;
  logic [21:0] obs;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  multicycle_ctrl dut (
    .CLK(CLK), .RST(RST), .op(op), .funct3(funct3), .funct7_5(funct7_5), .Zero(Zero),
    .MemReady(MemReady), .MemRead(MemRead), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc),
    .Illegal(Illegal), .State(State)
  );

  assign obs = {MemRead, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ResultSrc, ALUSrcA,
                ALUSrcB, ALUControl, ImmSrc, Illegal, State};

  task automatic check(input string tag, input logic [21:0] got, input logic [21:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected output vector for a given state, from the per-state rules of the controller
  function automatic logic [21:0] model(input int st, input logic [6:0] o, input logic [2:0] f3,
                                        input logic f7, input logic mr, input logic z);
    logic       mrd, mwr, adr, irw, pcw, rgw, ill;
    logic [1:0] res, sa, sb, imm;
    logic [2:0] alu, alu_fn;
    {mrd, mwr, adr, irw, pcw, rgw, ill} = '0;
    res = 2'd0; sa = 2'd0; sb = 2'd0; alu = 3'd0;
    if (o == 7'b0100011)      imm = 2'd1;
    else if (o == 7'b1100011) imm = 2'd2;
    else if (o == 7'b1101111) imm = 2'd3;
    else                      imm = 2'd0;
    case (f3)
      3'd0:    alu_fn = (o[5] && f7) ? 3'd1 : 3'd0;
      3'd2:    alu_fn = 3'd5;
      3'd6:    alu_fn = 3'd3;
      3'd7:    alu_fn = 3'd2;
      default: alu_fn = 3'd0;
    endcase
    case (st)
      0:  begin mrd = 1; sb = 2; res = 2; irw = mr; pcw = mr; end
      1:  begin sa = 1; sb = 1; end
      2:  begin sa = 2; sb = 1; end
      3:  begin mrd = 1; adr = 1; end
      4:  begin res = 1; rgw = 1; end
      5:  begin mwr = 1; adr = 1; end
      6:  begin sa = 2; sb = 0; alu = alu_fn; end
      7:  begin rgw = 1; end
      8:  begin sa = 2; sb = 1; alu = alu_fn; end
      9:  begin sa = 1; sb = 2; pcw = 1; end
      10: begin sa = 2; alu = 3'd1; pcw = z; end
      11: begin ill = 1; end
      default: ;
    endcase
    return {mrd, mwr, adr, irw, pcw, rgw, res, sa, sb, alu, imm, ill, 4'(st)};
  endfunction

  // Called at posedge+1: apply inputs, check at negedge, advance to next posedge+1
  task automatic cyc(input int st, input logic mr, input logic z);
    MemReady = mr;
    Zero     = z;
    @(negedge CLK);
    check($sformatf("st%0d_op%b", st, op), obs, model(st, op, funct3, funct7_5, mr, z));
    @(posedge CLK);
    #1;
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  // cls: 0 lw, 1 sw, 2 R, 3 I, 4 jal, 5 beq; wf/wm are fetch/memory wait cycles
  task automatic run_instr(input int cls, input int wf, input int wm, input logic [2:0] f3,
                           input logic f7, input logic zb);
    case (cls)
      0:       op = 7'b0000011;
      1:       op = 7'b0100011;
      2:       op = 7'b0110011;
      3:       op = 7'b0010011;
      4:       op = 7'b1101111;
      default: op = 7'b1100011;
    endcase
    funct3   = f3;
    funct7_5 = f7;
    repeat (wf) cyc(0, 1'b0, rb());
    cyc(0, 1'b1, rb());
    cyc(1, rb(), rb());
    case (cls)
      0: begin
        cyc(2, rb(), rb());
        repeat (wm) cyc(3, 1'b0, rb());
        cyc(3, 1'b1, rb());
        cyc(4, rb(), rb());
      end
      1: begin
        cyc(2, rb(), rb());
        repeat (wm) cyc(5, 1'b0, rb());
        cyc(5, 1'b1, rb());
      end
      2: begin cyc(6, rb(), rb()); cyc(7, rb(), rb()); end
      3: begin cyc(8, rb(), rb()); cyc(7, rb(), rb()); end
      4: begin cyc(9, rb(), rb()); cyc(7, rb(), rb()); end
      default: cyc(10, rb(), zb);
    endcase
  endtask

  initial begin
    RST      = 1'b0;
    MemReady = 1'b1;
    Zero     = 1'b1;
    op       = 7'b0100011;
    funct3   = 3'd0;
    funct7_5 = 1'b1;
    repeat (2) begin
      @(negedge CLK);
      check("reset_hold", obs, 22'd0);
    end
    @(posedge CLK);
    #1 RST = 1'b1;

    run_instr(0, 0, 0, 3'd0, 1'b0, 1'b0);
    run_instr(1, 0, 3, 3'd2, 1'b0, 1'b0);
    run_instr(5, 0, 0, 3'd0, 1'b0, 1'b1);
    run_instr(5, 0, 0, 3'd0, 1'b0, 1'b0);
    run_instr(2, 0, 0, 3'd0, 1'b1, 1'b0);
    run_instr(3, 0, 0, 3'd0, 1'b1, 1'b0);
    run_instr(3, 0, 0, 3'd2, 1'b0, 1'b0);
    run_instr(4, 1, 0, 3'd0, 1'b0, 1'b0);
    run_instr(0, 2, 2, 3'd7, 1'b1, 1'b1);

    for (int i = 0; i < 60; i++)
      run_instr(int'($urandom_range(0, 5)), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 2)), 3'($urandom), rb(), rb());

    // Reset while a store is waiting in MEMWRITE
    op = 7'b0100011;
    cyc(0, 1'b1, 1'b0);
    cyc(1, 1'b0, 1'b0);
    cyc(2, 1'b0, 1'b0);
    cyc(5, 1'b0, 1'b0);
    MemReady = 1'b0;
    @(negedge CLK);
    check("mw_before_rst", obs, model(5, op, funct3, funct7_5, 1'b0, Zero));
    #2 RST = 1'b0;
    #1 check("mw_rst_drop", obs, 22'd0);
    @(posedge CLK);
    #1 RST = 1'b1;
    run_instr(2, 0, 0, 3'd6, 1'b0, 1'b0);

    // Unsupported opcode: terminal ILLEGAL until reset
    op = 7'b1111111;
    cyc(0, 1'b1, 1'b0);
    cyc(1, 1'b1, 1'b0);
    repeat (22) cyc(11, rb(), rb());
    RST = 1'b0;
    @(negedge CLK);
    check("ill_rst", obs, 22'd0);
    @(posedge CLK);
    #1 RST = 1'b1;
    cyc(0, 1'b0, 1'b0);
    run_instr(1, 0, 1, 3'd0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main sequencing FSM for the multicycle variant of the RV32I core. It replaces the single-cycle combinational control unit, driving the shared ALU, unified instruction/data memory port, IR/PC enables and register-file write across multiple cycles per instruction. It stalls on a memory ready handshake. The main decoder, ALU decoder and ImmSrc decoder are internal.

Parameters:
OP_WIDTH, 7, opcode field width
FUNCT3_WIDTH, 3, funct3 field width
ALU_CTRL_WIDTH, 3, ALUControl width (000 add, 001 sub, 010 and, 011 or, 101 slt)
IMM_SRC_WIDTH, 2, ImmSrc width (00 I, 01 S, 10 B, 11 J)
STATE_WIDTH, 4, state register / debug port width

Ports:
CLK  input  1  clock, rising edge
RST  input  1  reset, asynchronous, active-low
op  input  OP_WIDTH  IR[6:0]
funct3  input  FUNCT3_WIDTH  IR[14:12]
funct7_5  input  1  IR[30]
Zero  input  1  ALU zero flag
MemReady  input  1  memory completes the current access this cycle
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
AdrSrc  output  1  0 = PC, 1 = ALUOut as memory address
IRWrite  output  1  latch instruction and OldPC
PCWrite  output  1  PC register enable
RegWrite  output  1  register-file write enable
ResultSrc  output  2  00 ALUOut, 01 Data reg, 10 ALUResult
ALUSrcA  output  2  00 PC, 01 OldPC, 10 A reg
ALUSrcB  output  2  00 B reg, 01 ImmExt, 10 constant 4
ALUControl  output  ALU_CTRL_WIDTH  ALU operation
ImmSrc  output  IMM_SRC_WIDTH  immediate format
Illegal  output  1  sticky unsupported-opcode flag
State  output  STATE_WIDTH  current state (debug)

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BEQ=10, ILLEGAL=11. Codes 12-15 go to FETCH.
- Reset: RST=0 asynchronously sets state to FETCH. While RST=0, all outputs are forced to 0, including State and Illegal.
- Outputs are Moore decodes of state, except PCWrite, IRWrite and the DECODE/MEMADR next-state logic. Any output not listed for a state is 0. All signals use ALUOp 00 (add) unless stated.
- FETCH: MemRead=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10. IRWrite=PCWrite=MemReady. Stays in FETCH while MemReady=0. Goes to DECODE when MemReady=1.
- DECODE: ALUSrcA=01, ALUSrcB=01 (computes branch target). Next state by op:
  - 0000011 or 0100011: MEMADR
  - 0110011: EXECUTER
  - 0010011: EXECUTEI
  - 1101111: JAL
  - 1100011: BEQ
  - anything else: ILLEGAL
- MEMADR: ALUSrcA=10, ALUSrcB=01. Goes to MEMREAD if op[5]=0, else MEMWRITE.
- MEMREAD: MemRead=1, AdrSrc=1. Holds until MemReady=1, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next state FETCH.
- MEMWRITE: MemWrite=1, AdrSrc=1. MemWrite stays asserted continuously while waiting. Goes to FETCH on MemReady=1.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next state ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next state ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next state FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCWrite=1 (PC <- ALUOut target). Next state ALUWB (rd <- PC+4).
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00. PCWrite=Zero. Next state FETCH.
- ILLEGAL: Illegal=1 and every other enable is 0. The state is terminal; only RST exits it.
- ALU decoder:
  - ALUOp 00 gives 000; ALUOp 01 gives 001.
  - ALUOp 10 decodes funct3:
    - 000: 001 if (op[5] & funct7_5), else 000
    - 010: 101
    - 110: 011
    - 111: 010
    - other: 000
- ImmSrc decodes from op in every state:
  - 0100011: 01
  - 1100011: 10
  - 1101111: 11
  - else: 00
- Latency with MemReady tied high:
  - lw: 5 cycles
  - sw, R-type, I-type ALU, jal: 4 cycles
  - beq: 3 cycles
- Each memory wait cycle adds 1 cycle.
- Simultaneous events: MemReady outside FETCH, MEMREAD and MEMWRITE is ignored. Zero outside BEQ is ignored.
- Reset mid-operation: MemWrite and RegWrite drop in the same cycle RST falls; no partial retire.

Test Plan:
1. Hold RST=0, then release with MemReady=1. During reset all outputs are 0 and State=0. The first cycle after release shows MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=10, ALUControl=000.
2. lw (op=0000011) with MemReady=1 -> State sequence 0,1,2,3,4,0. RegWrite=1 only in state 4, with ResultSrc=01. ImmSrc=00.
3. sw (op=0100011) with MemReady=0 for 3 cycles in MEMWRITE -> MemWrite=1 for exactly 4 consecutive cycles with AdrSrc=1 and ImmSrc=01, then State=0. RegWrite is never 1.
4. beq (op=1100011): with Zero=1, BEQ cycle shows PCWrite=1, ALUControl=001, ImmSrc=10. With Zero=0, PCWrite=0. Both cases return to FETCH after 3 cycles.
5. R-type op=0110011, funct3=000, funct7_5=1 -> ALUControl=001 in EXECUTER. I-type op=0010011, funct3=000, funct7_5=1 -> ALUControl=000. funct3=010 -> 101. Each is followed by ALUWB with RegWrite=1.
6. op=1111111 at DECODE -> State=11, Illegal=1 held for 20+ cycles with all enables 0. Separately, RST=0 asserted mid-MEMWRITE -> MemWrite=0 immediately, and State=0 after release.
